// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-lite definitions.
//   - RESP_* : rresp/bresp encodings
//   - mr_state_e : state encoding of the axi_master_r read FSM
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StAddr = 2'b01,
      StData = 2'b10,
      StResp = 2'b11
   } mr_state_e;

endpackage

// File: rtl/axi_master_r_if.sv
// axi_master_r_if: bundles the requester side and the AXI4-lite AR/R channels of axi_master_r.
//   Requester : req_valid, req_addr, req_ready, resp_valid, resp_data, resp_code, resp_timeout
//   AR channel: arvalid, araddr, arready
//   R channel : rvalid, rdata, rresp, rready
// Modports: master (the axi_master_r side), slave (requester + AXI slave side, e.g. a bench).
interface axi_master_r_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic [1:0]        resp_code;
   logic              resp_timeout;
   logic              arvalid;
   logic [ADDR_W-1:0] araddr;
   logic              arready;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rready;

   modport master (
      input  req_valid, req_addr, arready, rvalid, rdata, rresp,
      output req_ready, resp_valid, resp_data, resp_code, resp_timeout, arvalid, araddr, rready
   );

   modport slave (
      output req_valid, req_addr, arready, rvalid, rdata, rresp,
      input  req_ready, resp_valid, resp_data, resp_code, resp_timeout, arvalid, araddr, rready
   );

endinterface

// File: rtl/axi_timeout_cnt.sv
// axi_timeout_cnt: saturating cycle counter with a run-time limit.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : reset count to zero (has priority over enable)
//   enable     : count this cycle
//   limit      : number of enabled cycles allowed
//   expired    : high during the enabled cycle that uses up the last allowed cycle
// Only instantiated by axi_master_r when AXI_MR_TIMEOUT_EN is defined.
module axi_timeout_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W:0]   cnt_inc;

   assign cnt_inc = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
   // cnt_q counts cycles already spent, so this cycle is number cnt_q+1.
   assign expired = enable && (cnt_inc >= {1'b0, limit});

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_inc[W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/axi_master_r.sv
// axi_master_r: AXI4-lite read-channel master, one outstanding single-word read.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : axi_master_r_if.master (requester req/resp + AR/R channels)
// All bus outputs are flops loaded from the next-state decode.
// Optional: define AXI_MR_TIMEOUT_EN to abort a transaction that waits TIMEOUT_CYCLES
// cycles in ADDR+DATA; the abort reports resp_code=2'b11 with resp_timeout=1 and
// drops arvalid/rready (intentional AXI deviation for hang recovery).
module axi_master_r
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic            clk,
   input logic            rst_n,
   axi_master_r_if.master bus
);

   mr_state_e         state_q, state_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic [1:0]        resp_code_q, resp_code_d;
   logic              resp_timeout_q, resp_timeout_d;
   logic              req_ready_q, req_ready_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic              resp_valid_q, resp_valid_d;

   logic accept;
   logic tmo_expired;

   // req_ready_q is low for one cycle after reset, so gate acceptance on it too.
   assign accept = (state_q == StIdle) && req_ready_q && bus.req_valid;

`ifdef AXI_MR_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic tmo_enable;

   assign tmo_enable = (state_q == StAddr) || (state_q == StData);

   axi_timeout_cnt #(
      .W(CNT_W)
   ) u_timeout_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accept),
      .enable (tmo_enable),
      .limit  (CNT_W'(TIMEOUT_CYCLES)),
      .expired(tmo_expired)
   );
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign tmo_expired        = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      araddr_d       = araddr_q;
      resp_data_d    = resp_data_q;
      resp_code_d    = resp_code_q;
      resp_timeout_d = resp_timeout_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               araddr_d = bus.req_addr;
               state_d  = StAddr;
            end
         end
         StAddr: begin
            // Handshake wins over a coinciding timeout.
            if (bus.arready) begin
               state_d = StData;
            end else if (tmo_expired) begin
               resp_code_d    = RESP_DECERR;
               resp_timeout_d = 1'b1;
               state_d        = StResp;
            end
         end
         StData: begin
            if (bus.rvalid) begin
               resp_data_d    = bus.rdata;
               resp_code_d    = bus.rresp;
               resp_timeout_d = 1'b0;
               state_d        = StResp;
            end else if (tmo_expired) begin
               resp_code_d    = RESP_DECERR;
               resp_timeout_d = 1'b1;
               state_d        = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      req_ready_d  = (state_d == StIdle);
      arvalid_d    = (state_d == StAddr);
      rready_d     = (state_d == StData);
      resp_valid_d = (state_d == StResp);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         araddr_q       <= '0;
         resp_data_q    <= '0;
         resp_code_q    <= RESP_OKAY;
         resp_timeout_q <= 1'b0;
         req_ready_q    <= 1'b0;
         arvalid_q      <= 1'b0;
         rready_q       <= 1'b0;
         resp_valid_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         araddr_q       <= araddr_d;
         resp_data_q    <= resp_data_d;
         resp_code_q    <= resp_code_d;
         resp_timeout_q <= resp_timeout_d;
         req_ready_q    <= req_ready_d;
         arvalid_q      <= arvalid_d;
         rready_q       <= rready_d;
         resp_valid_q   <= resp_valid_d;
      end
   end

   assign bus.req_ready    = req_ready_q;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_data    = resp_data_q;
   assign bus.resp_code    = resp_code_q;
   assign bus.resp_timeout = resp_timeout_q;
   assign bus.arvalid      = arvalid_q;
   assign bus.araddr       = araddr_q;
   assign bus.rready       = rready_q;

endmodule

// File: doc/axi_master_r.md
# axi_master_r

AXI4-lite read-channel master sitting directly upstream of the team's AXI4-lite read slave. It accepts single-word read requests from a local requester, drives the AR channel, collects the R channel and returns data plus response status to the requester. One outstanding transaction at a time; all outputs are registered.

## Interface

Parameters
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, cycles allowed per transaction before abort (used only with AXI_MR_TIMEOUT_EN)

Ports
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous and active-low
- req_valid  in  1  requester asks for a read
- req_addr  in  ADDR_W  read address, sampled with req_valid & req_ready
- req_ready  out  1  high only in IDLE
- resp_valid  out  1  one-cycle pulse: transaction finished
- resp_data  out  DATA_W  captured rdata; held until next capture
- resp_code  out  2  captured rresp, or 2'b11 on timeout
- resp_timeout  out  1  qualifies resp_valid: transaction aborted by timeout
- arvalid  out  1  AR channel valid
- araddr  out  ADDR_W  AR channel address
- arready  in  1  AR channel ready
- rvalid  in  1  R channel valid
- rdata  in  DATA_W  R channel data
- rresp  in  2  R channel response
- rready  out  1  R channel ready

## Operation

- States: IDLE, ADDR, DATA, RESP.
- IDLE: req_ready=1, arvalid=0, rready=0. On req_valid: latch req_addr into araddr, go ADDR.
- ADDR: arvalid=1, araddr stable. On arready: go DATA (arvalid low next cycle).
- DATA: rready=1. On rvalid: capture rdata→resp_data, rresp→resp_code, go RESP.
- RESP: resp_valid=1 for exactly this cycle, req_ready=0; unconditionally go IDLE.
- req_valid outside IDLE is ignored (not queued).
- arvalid, once high, stays high with constant araddr until arready (timeout excepted).
- resp_code passes rresp verbatim; nonzero is an error for the requester to interpret.
- Reset: any state → IDLE at the edge where rst_n is sampled low. Reset values: req_ready=0 during reset then 1, resp_valid=0, resp_data=0, resp_code=0, resp_timeout=0, arvalid=0, araddr=0, rready=0. A transaction interrupted by reset produces no response.

## Timing

- req accepted at edge N → arvalid high from N+1.
- arready at edge M → rready high from M+1, arvalid low from M+1.
- rvalid sampled at edge K → resp_valid high cycle K+1; back in IDLE (req_ready=1) from K+2.
- Minimum turnaround with zero-wait slave: 4 cycles request-to-request.
- rready low in every state except DATA; a slave raising rvalid early is not acknowledged until DATA.

## Configuration

- AXI_MR_TIMEOUT_EN defined: a counter clears on request acceptance and increments in ADDR and DATA. On reaching TIMEOUT_CYCLES without the awaited handshake: go RESP with resp_code=2'b11, resp_timeout=1, resp_data unchanged; arvalid/rready drop. Dropping arvalid is a deliberate AXI deviation for hang recovery. If the handshake and the limit coincide in the same cycle, the handshake wins.
- Undefined: no counter; master waits indefinitely; resp_timeout tied 0.

## Structure

- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, state encoding for this FSM.
- One sub-module, axi_timeout_cnt (clear, enable, limit → expired), instantiated only under AXI_MR_TIMEOUT_EN.

## Test plan

- Zero-wait slave, req_addr=0x0000_0010, rdata=0xDEAD_BEEF, rresp=0 → araddr=0x10, resp_valid one cycle at K+1, resp_data=0xDEADBEEF, resp_code=0.
- arready delayed 5 cycles → arvalid and araddr stable all 5 cycles; rready first high the cycle after arready.
- rresp=2'b10 with rdata=0x1234 → resp_code=2'b10, resp_data=0x1234, resp_timeout=0.
- req_valid held high through a transaction with a different addr → ignored until IDLE; the second read issues exactly once afterwards.
- rst_n low for one cycle while in DATA → next cycle all outputs at reset values; no resp_valid; a following request completes normally.
- AXI_MR_TIMEOUT_EN, TIMEOUT_CYCLES=8, arready never asserted → resp_valid with resp_code=2'b11, resp_timeout=1; arvalid low after abort.
